// File: rtl/uart_rx_deframer_if.sv
// Receive-word handshake between the UART deframer and its consumer.
// The deframer drives rx_data/rx_valid. The consumer drives rx_ready.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer.
// The serial line is sampled with a 16x (OVERSAMPLE) baud tick.
// Start, data and stop bits are recovered at bit centres.
// Received words are presented on a valid/ready handshake.
// Framing errors and overruns are flagged with one-cycle pulses.
module uart_rx_deframer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               baud_tick_16x,
    input  logic               rx,
    uart_rx_deframer_if.master rx_if,
    output logic               framing_err,
    output logic               overrun,
    output logic               rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM, counters, shift register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
            framing_err    <= 1'b0;
            overrun        <= 1'b0;
            rx_busy        <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            overrun     <= 1'b0;
            // Consumption comes first so that a word loading on the same edge wins.
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (baud_tick_16x) begin
                        if (tick_cnt == TICK_MID) begin
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (baud_tick_16x) begin
                        tick_cnt <= tick_cnt + TW'(1);
                        if (tick_cnt == TICK_LAST) begin
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            if (bit_idx == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end
                    end
                end

                STOP: begin
                    if (baud_tick_16x) begin
                        tick_cnt <= tick_cnt + TW'(1);
                        if (tick_cnt == TICK_LAST) begin
                            if (rx_s) begin
                                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                                    rx_if.rx_data  <= shift_reg;
                                    rx_if.rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                framing_err <= 1'b1;
                                state       <= BRK;
                            end
                        end
                    end
                end

                BRK: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
